// File: rtl/imem_loader_pkg.sv
// Shared state encoding and constants for the instruction-memory loader.
// Optional byte-checksum stage is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian byte-to-word assembler; o_word_valid flags the edge
// on which the 4th byte is accepted, with the full word on o_word.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic [7:0]  i_byte,
   input  logic        i_strobe,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  r_idx;
   logic [23:0] r_acc;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_strobe) begin
         r_idx <= r_idx + 2'd1;
         case (r_idx)
            2'd0:    r_acc[23:16] <= i_byte;
            2'd1:    r_acc[15:8]  <= i_byte;
            2'd2:    r_acc[7:0]   <= i_byte;
            default: r_acc        <= r_acc;
         endcase
      end
   end

   // Last byte bypasses the register so the word is ready on its edge.
   assign o_word       = {r_acc, i_byte};
   assign o_word_valid = i_strobe && (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the instruction-memory write port.
// Define IMEM_LOADER_CHECKSUM_EN for the trailing XOR checksum stage.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [7:0]        i_in_byte,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [ADDR_W:0]   o_word_count,
   output logic              o_cpu_run,
   output logic              o_done,
   output logic              o_overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic              o_chk_err
`endif
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_enter_done;
   logic              w_run_ok;
   logic              w_start_load;
   logic              w_strobe;
   logic              w_wr;
   logic              w_word_valid;
   logic [31:0]       w_word;

   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_cnt;
   logic              r_cpu_run;
   logic              r_ovf;
   logic              r_term_halt;
   logic              r_term_ovf;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_xor;
   logic              r_chk_err;
`endif

   assign w_strobe     = i_in_valid && (r_state == ST_LOAD);
   assign w_start_load = i_start &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
   // Once a terminating word is queued nothing else is written.
   assign w_wr         = w_word_valid && !r_term_halt && !r_term_ovf;

   byte_assembler u_asm (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (w_start_load),
      .i_byte       (i_in_byte),
      .i_strobe     (w_strobe),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_enter_done = 1'b0;
      w_run_ok     = 1'b1;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (r_we && r_term_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_state_nxt  = ST_CHECK;
`else
               w_state_nxt  = ST_DONE;
               w_enter_done = 1'b1;
`endif
            end else if (r_we && r_term_ovf) begin
               w_state_nxt  = ST_DONE;
               w_enter_done = 1'b1;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (i_in_valid) begin
               w_state_nxt  = ST_DONE;
               w_enter_done = 1'b1;
               w_run_ok     = (i_in_byte == r_xor);
            end
         end
`endif
         ST_DONE: begin
            if (i_start) begin
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_cpu_run   <= 1'b0;
         r_ovf       <= 1'b0;
         r_term_halt <= 1'b0;
         r_term_ovf  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_xor       <= '0;
         r_chk_err   <= 1'b0;
`endif
      end else begin
         r_we <= w_wr;
         if (w_wr) begin
            r_wdata <= w_word;
            r_addr  <= r_cnt[ADDR_W-1:0];
            if (w_word == HALT_WORD) begin
               r_term_halt <= 1'b1;
            end else if (r_cnt == LAST_CNT) begin
               r_term_ovf  <= 1'b1;
            end
         end
         if (r_we) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_we && (r_term_halt || r_term_ovf)) begin
            r_term_halt <= 1'b0;
            r_term_ovf  <= 1'b0;
         end
         if (w_enter_done) begin
            r_cpu_run <= w_run_ok;
            r_ovf     <= r_term_ovf;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (w_strobe) begin
            r_xor <= r_xor ^ i_in_byte;
         end
         if (w_enter_done) begin
            r_chk_err <= !w_run_ok;
         end
`endif
         if (w_start_load) begin
            r_cnt       <= '0;
            r_cpu_run   <= 1'b0;
            r_ovf       <= 1'b0;
            r_term_halt <= 1'b0;
            r_term_ovf  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= '0;
            r_chk_err   <= 1'b0;
`endif
         end
      end
   end

   assign o_in_ready   = (r_state == ST_LOAD) || (r_state == ST_CHECK);
   assign o_mem_we     = r_we;
   assign o_mem_addr   = r_addr;
   assign o_mem_wdata  = r_wdata;
   assign o_word_count = r_cnt;
   assign o_cpu_run    = r_cpu_run;
   assign o_done       = (r_state == ST_DONE);
   assign o_overflow   = r_ovf;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign o_chk_err    = r_chk_err;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream and writes 32-bit words into instruction memory.
- Holds the processor in reset-equivalent idle (cpu_run=0) while loading; asserts cpu_run once the program is complete.
- Sits between the host/serial byte source and the instruction-memory write port, beside the pipeline top level.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a new load.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid & in_ready at a rising edge.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word data.
- word_count  out  ADDR_W+1  number of words written in the current load.
- cpu_run  out  1  pipeline enable.
- done  out  1  load finished.
- overflow  out  1  memory filled without HALT_WORD.

Behaviour:
- One clock; rst is synchronous and active-high. All state is registered.
- Reset values: state=IDLE; in_ready, mem_we, cpu_run, done and overflow = 0; mem_addr, mem_wdata and word_count = 0. The byte index and the partial word are cleared.
- States:
  - IDLE: in_ready=0; start -> LOAD.
  - LOAD: in_ready=1; byte assembly and word writes.
  - DONE: in_ready=0, done=1, cpu_run=1.
- Entering LOAD, on the edge that samples start, clears word_count, the byte index, overflow, done and cpu_run.
- Assembly is big-endian. The first byte accepted goes to [31:24], then [23:16], [15:8], [7:0]. The byte index counts 0..3 and wraps.
- Write timing: on the edge that accepts the 4th byte, the assembled word is copied to mem_wdata and mem_addr=word_count[ADDR_W-1:0]. mem_we=1 for exactly the following cycle.
  - word_count increments on the edge that ends that mem_we cycle.
  - Byte acceptance continues during the mem_we cycle, because the assembly register is independent of mem_wdata.
- Termination is evaluated on the same edge that accepts the 4th byte:
  - If the word equals HALT_WORD, it is still written. The next state is DONE, entered after the mem_we cycle; in_ready drops at that point.
  - Else, if word_count equals 2^ADDR_W-1 (the last address), the word is written, the next state is DONE, and overflow=1.
- Bytes offered after DONE are not accepted, because in_ready=0.
- start while in LOAD is ignored.
- start in DONE restarts the load: state goes to LOAD and cpu_run, done and overflow go to 0 on that edge. Old memory contents are not cleared.
- in_valid=0 gaps of any length are allowed; a partial word is held indefinitely.
- rst mid-load: the partial word is discarded, any pending mem_we is cancelled, and state returns to IDLE.
- rst has priority over start.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR of every byte accepted in LOAD is kept.
  - After the HALT_WORD write, the state goes to CHECK (in_ready=1) and exactly one byte is accepted.
  - If that byte equals the XOR, state goes to DONE with cpu_run=1.
  - Otherwise state goes to DONE with cpu_run=0 and added output chk_err=1.
  - chk_err is cleared by rst and by start.
- Undefined: no CHECK state, no chk_err port, and HALT_WORD goes directly to DONE.

Decomposition:
- Package imem_loader_pkg: state encoding (IDLE, LOAD, CHECK, DONE), BYTES_PER_WORD=4, HALT_WORD default constant.
- Sub-module byte_assembler:
  - Inputs: clk, rst, clear, byte, strobe.
  - Outputs: word[31:0], word_valid, a one-cycle pulse on the 4th byte.
- The top level holds the FSM, counters and memory-port registers.

Test Plan:
- Word write: reset, start, stream 12 34 56 78 -> one mem_we pulse, mem_addr=0, mem_wdata=32'h12345678, word_count=1, cpu_run=0.
- Halt termination: stream 3 words followed by FF FF FF FF -> 4 writes at addresses 0..3, the last with wdata=32'hFFFFFFFF; then done=1, cpu_run=1, in_ready=0.
- Flow control: in_valid toggling with random gaps, including a gap inside a word -> identical words and addresses to the gapless run; no extra mem_we.
- Overflow: ADDR_W=2, stream 4 non-halt words -> writes at addresses 0..3, done=1, overflow=1, word_count=4.
- Reset and restart: rst after 2 bytes of word 1, then start and stream AA BB CC DD -> write at address 0 with wdata=32'hAABBCCDD, with no trace of the earlier bytes. Start in DONE -> cpu_run=0 on the next cycle.
- Checksum (IMEM_LOADER_CHECKSUM_EN), stream 01 02 03 04 FF FF FF FF:
  - Trailing byte 04 (the XOR of all eight bytes) -> cpu_run=1, chk_err=0.
  - Trailing byte 05 -> cpu_run=0, chk_err=1.
